// File: rtl/pe_pkg.sv
// Shared constants and types for the systolic processing element.
//   PE_DATA_W : default operand width (signed)
//   PE_ACC_W  : default accumulator / result width (signed)
//   pe_data_t : signed operand type at the default width
//   pe_acc_t  : signed accumulator type at the default width
package pe_pkg;

  localparam int unsigned PE_DATA_W = 8;
  localparam int unsigned PE_ACC_W  = 32;

  typedef logic signed [PE_DATA_W-1:0] pe_data_t;
  typedef logic signed [PE_ACC_W-1:0]  pe_acc_t;

endpackage

// File: rtl/pe_mul.sv
// Combinational signed DATA_W x DATA_W multiplier with a full-width product.
// The product is 2*DATA_W bits wide, so even -2^(DATA_W-1) squared fits.
//   a, b    : signed operands, DATA_W bits
//   product : signed product, 2*DATA_W bits
module pe_mul
  import pe_pkg::*;
#(
  parameter int unsigned DATA_W = PE_DATA_W
) (
  input  logic signed [DATA_W-1:0]   a,
  input  logic signed [DATA_W-1:0]   b,
  output logic signed [2*DATA_W-1:0] product
);

  logic signed [2*DATA_W-1:0] a_ext;
  logic signed [2*DATA_W-1:0] b_ext;

  always_comb begin
    a_ext   = (2*DATA_W)'(a);
    b_ext   = (2*DATA_W)'(b);
    product = a_ext * b_ext;
  end

endmodule

// File: rtl/systolic_pe.sv
// Signed multiply-accumulate processing element for a systolic array.
// Every cycle: acc <= acc + a*b, a_out <= a, b_out <= b. No enable, no
// clear other than rst (synchronous, active-high, has priority).
// Optional macro PE_SATURATE_EN: accumulator clamps at the signed ACC_W
// limits instead of wrapping.
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset
//   a            : signed operand from the left neighbour
//   b            : signed operand from the top neighbour
//   a_out        : registered a, to the right neighbour
//   b_out        : registered b, to the bottom neighbour
//   final_result : accumulator register
module systolic_pe
  import pe_pkg::*;
#(
  parameter int unsigned DATA_W = PE_DATA_W,
  parameter int unsigned ACC_W  = PE_ACC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] a_out,
  output logic signed [DATA_W-1:0] b_out,
  output logic signed [ACC_W-1:0]  final_result
);

  logic signed [2*DATA_W-1:0] product;
  logic signed [ACC_W-1:0]    product_ext;
  logic signed [ACC_W-1:0]    sum;
  logic signed [ACC_W-1:0]    acc_next;

  pe_mul #(
    .DATA_W (DATA_W)
  ) u_mul (
    .a       (a),
    .b       (b),
    .product (product)
  );

  always_comb begin
    // Size cast keeps signedness, so this sign-extends the product.
    product_ext = ACC_W'(product);
    sum         = final_result + product_ext;
  end

`ifdef PE_SATURATE_EN
  logic                    overflow;
  logic signed [ACC_W-1:0] sat_max;
  logic signed [ACC_W-1:0] sat_min;

  always_comb begin
    sat_max            = '1;
    sat_max[ACC_W-1]   = 1'b0;
    sat_min            = '0;
    sat_min[ACC_W-1]   = 1'b1;
    // Overflow only when both addends share a sign and the sum flips it;
    // the direction of the clamp follows the addends' sign.
    overflow = (final_result[ACC_W-1] == product_ext[ACC_W-1]) &&
               (sum[ACC_W-1] != final_result[ACC_W-1]);
    acc_next = sum;
    if (overflow) begin
      acc_next = final_result[ACC_W-1] ? sat_min : sat_max;
    end
  end
`else
  always_comb begin
    acc_next = sum;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      final_result <= '0;
      a_out        <= '0;
      b_out        <= '0;
    end else begin
      final_result <= acc_next;
      a_out        <= a;
      b_out        <= b;
    end
  end

endmodule

// File: tb/tb_systolic_pe.sv
// Scoreboard bench for systolic_pe: two instances (ACC_W=32 and ACC_W=16)
// share the same stimulus; the driver pushes expected outputs computed with
// plain integer arithmetic, and a monitor pops and compares after each edge.
module tb_systolic_pe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic signed [7:0] a   = '0;
  logic signed [7:0] b   = '0;

  logic signed [7:0]  a_out32, b_out32, a_out16, b_out16;
  logic signed [31:0] r32;
  logic signed [15:0] r16;

  systolic_pe #(.DATA_W(8), .ACC_W(32)) u_pe32 (
    .clk (clk), .rst (rst), .a (a), .b (b),
    .a_out (a_out32), .b_out (b_out32), .final_result (r32)
  );

  systolic_pe #(.DATA_W(8), .ACC_W(16)) u_pe16 (
    .clk (clk), .rst (rst), .a (a), .b (b),
    .a_out (a_out16), .b_out (b_out16), .final_result (r16)
  );

  typedef struct {
    longint r32;
    longint r16;
    longint ao;
    longint bo;
  } exp_t;

  exp_t   sb[$];
  longint m32 = 0;
  longint m16 = 0;
  int     passed = 0;
  int     total  = 0;

  // Bring an exact integer sum into a signed w-bit result.
  function automatic longint fit(longint x, int w);
    longint hi, lo, span, m;
    span = longint'(1) <<< w;
    hi   = (longint'(1) <<< (w - 1)) - 1;
    lo   = -(longint'(1) <<< (w - 1));
`ifdef PE_SATURATE_EN
    m = x;
    if (x > hi) m = hi;
    if (x < lo) m = lo;
`else
    m = x & (span - 1);
    if (m > hi) m = m - span;
`endif
    return m;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step(input bit r, input int av, input int bv);
    exp_t e;
    @(negedge clk);
    rst = r;
    a   = 8'(av);
    b   = 8'(bv);
    if (r) begin
      m32 = 0;
      m16 = 0;
      e.ao = 0;
      e.bo = 0;
    end else begin
      m32 = fit(m32 + longint'(av * bv), 32);
      m16 = fit(m16 + longint'(av * bv), 16);
      e.ao = av;
      e.bo = bv;
    end
    e.r32 = m32;
    e.r16 = m16;
    sb.push_back(e);
  endtask

  // Monitor: outputs are valid every cycle; compare one entry per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("acc32",   longint'(r32),     e.r32);
        check("acc16",   longint'(r16),     e.r16);
        check("a_out32", longint'(a_out32), e.ao);
        check("b_out32", longint'(b_out32), e.bo);
        check("a_out16", longint'(a_out16), e.ao);
        check("b_out16", longint'(b_out16), e.bo);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int av, bv;
    // Reset with nonzero operands present.
    step(1, 5, 5);
    // Accumulation sequence: 200, 0, 20, 29, 35.
    step(0, 10, 20);
    step(0, -10, 20);
    step(0, -5, -4);
    step(0, 3, 3);
    step(0, 2, 3);
    // Mid-run reset discards 9*9, then accumulate from 0.
    step(1, 9, 9);
    step(0, 1, 1);
    // Forwarding pulse.
    step(0, 7, -3);
    step(0, 0, 0);
    step(0, 0, 0);
    // Extremes from reset: 16384 then 128.
    step(1, 0, 0);
    step(0, -128, -128);
    step(0, -128, 127);
    // Overflow on the 16-bit instance: 16129, 32258, then wrap or clamp.
    step(1, 0, 0);
    step(0, 127, 127);
    step(0, 127, 127);
    step(0, 127, 127);
    step(0, 127, 127);
    // Negative direction on the 16-bit instance.
    step(1, 0, 0);
    for (int unsigned i = 0; i < 4; i++) step(0, -128, 127);
    // Randomised operands with occasional resets.
    for (int unsigned i = 0; i < 400; i++) begin
      av = int'($urandom_range(255, 0)) - 128;
      bv = int'($urandom_range(255, 0)) - 128;
      step(($urandom_range(39, 0) == 0), av, bv);
    end
    step(0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", longint'(sb.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
